// File: rtl/rf_pkg.sv
// Shared definitions for the per-core register-file slot array.
package rf_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_FETCH  = 3'd1,
    OP_LOCK   = 3'd2,
    OP_UNLOCK = 3'd3,
    OP_WRITE  = 3'd4,
    OP_INVAL  = 3'd5
  } rf_op_e;

  typedef struct packed {
    logic valid;
    logic retrieving;
    logic locked;
  } rf_flags_t;

  localparam int unsigned FLAG_W = $bits(rf_flags_t);

  // Packed slot layout, MSB to LSB: flags, tag, value.
  function automatic int unsigned slot_w(input int unsigned tag_w, input int unsigned val_w);
    return FLAG_W + tag_w + val_w;
  endfunction

  function automatic int unsigned tag_off(input int unsigned val_w);
    return val_w;
  endfunction

  function automatic int unsigned flags_off(input int unsigned tag_w, input int unsigned val_w);
    return tag_w + val_w;
  endfunction

endpackage

// File: rtl/rf_rr_arb.sv
// Round-robin arbiter with a registered grant that holds while stalled.
module rf_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned NUM_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             ready,
  output logic             gnt_valid,
  output logic [NUM_W-1:0] gnt_num
);

  logic             valid_q, valid_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     avail;
  logic             hs;
  int unsigned      idx;

  always_comb begin
    hs      = valid_q & ready;
    ptr_d   = ptr_q;
    avail   = req;
    valid_d = valid_q;
    num_d   = num_q;
    idx     = 0;
    if (hs) begin
      ptr_d = (32'(num_q) == N - 1) ? '0 : num_q + 1'b1;
      avail[num_q] = 1'b0;
    end
    if (!valid_q || ready) begin
      valid_d = 1'b0;
      // Scan farthest-first so the slot nearest the pointer wins last.
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr_d) + N - 1 - k) % N;
        if (avail[NUM_W'(idx)]) begin
          valid_d = 1'b1;
          num_d   = NUM_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      num_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      num_q   <= num_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt_valid = valid_q;
  assign gnt_num   = num_q;

endmodule

// File: rtl/rf_slot_array.sv
// Per-core slot array: command port, round-robin memory fetch, packed state export.
module rf_slot_array import rf_pkg::*; #(
  parameter int unsigned NCORES = 4,
  parameter int unsigned TAG_W  = 16,
  parameter int unsigned VAL_W  = 16,
  localparam int unsigned NUM_W = $clog2(NCORES),
  localparam int unsigned W     = slot_w(TAG_W, VAL_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd_op,
  input  logic [NUM_W-1:0]    cmd_num,
  input  logic [TAG_W-1:0]    cmd_tag,
  input  logic [VAL_W-1:0]    cmd_data,
  output logic                cmd_ack,
  output logic                cmd_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [NUM_W-1:0]    mem_req_num,
  output logic [TAG_W-1:0]    mem_req_tag,
  input  logic                mem_rsp_valid,
  input  logic [NUM_W-1:0]    mem_rsp_num,
  input  logic [VAL_W-1:0]    mem_rsp_data,
  input  logic [NUM_W-1:0]    rd_num,
  output logic                rd_valid,
  output logic                rd_retrieving,
  output logic                rd_locked,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [VAL_W-1:0]    rd_val,
  output logic [NCORES*W-1:0] rf_out
);

  logic [NCORES-1:0] v_q, v_d, r_q, r_d, l_q, l_d, iss_q, iss_d;
  logic [TAG_W-1:0]  tag_q [NCORES];
  logic [TAG_W-1:0]  tag_d [NCORES];
  logic [VAL_W-1:0]  val_q [NCORES];
  logic [VAL_W-1:0]  val_d [NCORES];
  logic              ack_q, ack_d, err_q, err_d;
  logic              arb_valid;
  logic [NUM_W-1:0]  arb_num;
  logic              hs, known, legal, apply, in_range;
  rf_op_e            op;
  logic [W-1:0]      rd_slot;

  rf_rr_arb #(.N(NCORES)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (r_q & ~iss_q),
    .ready     (mem_req_ready),
    .gnt_valid (arb_valid),
    .gnt_num   (arb_num)
  );

  always_comb begin
    op       = rf_op_e'(cmd_op);
    in_range = 32'(cmd_num) < NCORES;
    known    = 1'b0;
    legal    = 1'b0;
    case (op)
      OP_FETCH, OP_WRITE, OP_INVAL: begin
        known = 1'b1;
        legal = in_range && !l_q[cmd_num] && !r_q[cmd_num];
      end
      OP_LOCK, OP_UNLOCK: begin
        known = 1'b1;
        legal = in_range;
      end
      default: ;
    endcase
    apply = cmd_valid && known && legal;
    ack_d = apply;
    err_d = cmd_valid && known && !legal;
    hs    = arb_valid && mem_req_ready;

    v_d   = v_q;
    r_d   = r_q;
    l_d   = l_q;
    iss_d = iss_q;
    tag_d = tag_q;
    val_d = val_q;
    // Legality used pre-cycle state, so a slot taking a response can only see LOCK/UNLOCK.
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (mem_rsp_valid && mem_rsp_num == NUM_W'(i) && r_q[i] && iss_q[i]) begin
        val_d[i] = mem_rsp_data;
        v_d[i]   = 1'b1;
        r_d[i]   = 1'b0;
        iss_d[i] = 1'b0;
      end
      if (hs && arb_num == NUM_W'(i)) iss_d[i] = 1'b1;
      if (apply && cmd_num == NUM_W'(i)) begin
        case (op)
          OP_FETCH: begin
            tag_d[i] = cmd_tag;
            v_d[i]   = 1'b0;
            r_d[i]   = 1'b1;
            iss_d[i] = 1'b0;
          end
          OP_LOCK:   l_d[i] = 1'b1;
          OP_UNLOCK: l_d[i] = 1'b0;
          OP_WRITE: begin
            tag_d[i] = cmd_tag;
            val_d[i] = cmd_data;
            v_d[i]   = 1'b1;
          end
          OP_INVAL:  v_d[i] = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      r_q   <= '0;
      l_q   <= '0;
      iss_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < NCORES; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      r_q   <= r_d;
      l_q   <= l_d;
      iss_q <= iss_d;
      ack_q <= ack_d;
      err_q <= err_d;
      tag_q <= tag_d;
      val_q <= val_d;
    end
  end

  always_comb begin
    rf_out  = '0;
    rd_slot = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      rf_out[i*W +: W] = {v_q[i], r_q[i], l_q[i], tag_q[i], val_q[i]};
    end
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (rd_num == NUM_W'(i)) rd_slot = rf_out[i*W +: W];
    end
  end

  assign rd_valid      = rd_slot[W-1];
  assign rd_retrieving = rd_slot[W-2];
  assign rd_locked     = rd_slot[W-3];
  assign rd_tag        = rd_slot[tag_off(VAL_W) +: TAG_W];
  assign rd_val        = rd_slot[VAL_W-1:0];

  assign cmd_ack       = ack_q;
  assign cmd_err       = err_q;
  assign mem_req_valid = arb_valid;
  assign mem_req_num   = arb_num;
  // A FETCHING, un-issued slot rejects every tag-changing command, so the held tag is stable.
  assign mem_req_tag   = tag_q[arb_num];

endmodule

// File: tb/tb_rf_slot_array.sv
// Randomized and directed check of rf_slot_array against a slot-level reference model.
module tb_rf_slot_array;

  localparam int N  = 4;
  localparam int TW = 16;
  localparam int VW = 16;
  localparam int NW = 2;
  localparam int W  = 3 + TW + VW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic [2:0]      cmd_op = '0;
  logic [NW-1:0]   cmd_num = '0;
  logic [TW-1:0]   cmd_tag = '0;
  logic [VW-1:0]   cmd_data = '0;
  logic            cmd_ack, cmd_err;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [NW-1:0]   mem_req_num;
  logic [TW-1:0]   mem_req_tag;
  logic            mem_rsp_valid = 1'b0;
  logic [NW-1:0]   mem_rsp_num = '0;
  logic [VW-1:0]   mem_rsp_data = '0;
  logic [NW-1:0]   rd_num = '0;
  logic            rd_valid, rd_retrieving, rd_locked;
  logic [TW-1:0]   rd_tag;
  logic [VW-1:0]   rd_val;
  logic [N*W-1:0]  rf_out;

  rf_slot_array #(.NCORES(N), .TAG_W(TW), .VAL_W(VW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_num(cmd_num),
    .cmd_tag(cmd_tag), .cmd_data(cmd_data),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_num(mem_req_num), .mem_req_tag(mem_req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_num(mem_rsp_num), .mem_rsp_data(mem_rsp_data),
    .rd_num(rd_num), .rd_valid(rd_valid), .rd_retrieving(rd_retrieving),
    .rd_locked(rd_locked), .rd_tag(rd_tag), .rd_val(rd_val),
    .rf_out(rf_out)
  );

  always #5 clk = ~clk;

  // Reference model: per-slot fields, outstanding request, round-robin pointer.
  bit            mv[N], mr[N], ml[N], mi[N];
  logic [TW-1:0] mt[N];
  logic [VW-1:0] mval[N];
  int            mptr, mreq_n;
  bit            mreq_v, mack, merr;

  int  n_vec  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;
  logic [N*W-1:0] saved;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] exp_rf();
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = {mv[i], mr[i], ml[i], mt[i], mval[i]};
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mr[i] = 0; ml[i] = 0; mi[i] = 0; mt[i] = '0; mval[i] = '0;
    end
    mptr = 0; mreq_n = 0; mreq_v = 0; mack = 0; merr = 0;
  endtask

  task automatic model_step();
    bit            nv[N], nr[N], nl[N], ni[N];
    logic [TW-1:0] nt[N];
    logic [VW-1:0] nval[N];
    bit            hs, known, legal, found;
    int            n, s;
    nv = mv; nr = mr; nl = ml; ni = mi; nt = mt; nval = mval;
    hs = mreq_v && mem_req_ready;
    if (mem_rsp_valid && mr[mem_rsp_num] && mi[mem_rsp_num]) begin
      nval[mem_rsp_num] = mem_rsp_data;
      nv[mem_rsp_num] = 1; nr[mem_rsp_num] = 0; ni[mem_rsp_num] = 0;
    end
    if (hs) ni[mreq_n] = 1;
    n     = int'(cmd_num);
    known = cmd_valid && (cmd_op >= 3'd1) && (cmd_op <= 3'd5);
    legal = (cmd_op == 3'd2 || cmd_op == 3'd3) ? 1'b1 : (!ml[n] && !mr[n]);
    mack  = known && legal;
    merr  = known && !legal;
    if (mack) begin
      case (cmd_op)
        3'd1: begin nt[n] = cmd_tag; nv[n] = 0; nr[n] = 1; ni[n] = 0; end
        3'd2: nl[n] = 1;
        3'd3: nl[n] = 0;
        3'd4: begin nt[n] = cmd_tag; nval[n] = cmd_data; nv[n] = 1; end
        default: nv[n] = 0;
      endcase
    end
    if (!mreq_v || mem_req_ready) begin
      if (hs) mptr = (mreq_n + 1) % N;
      found = 0;
      for (int k = 0; k < N; k++) begin
        s = (mptr + k) % N;
        if (!found && mr[s] && !mi[s] && !(hs && s == mreq_n)) begin
          found = 1; mreq_n = s;
        end
      end
      mreq_v = found;
    end
    mv = nv; mr = nr; ml = nl; mi = ni; mt = nt; mval = nval;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ack", N*W'(cmd_ack), N*W'(mack));
      check("cmd_err", N*W'(cmd_err), N*W'(merr));
      check("req_valid", N*W'(mem_req_valid), N*W'(mreq_v));
      if (mreq_v) begin
        check("req_num", N*W'(mem_req_num), N*W'(mreq_n));
        check("req_tag", N*W'(mem_req_tag), N*W'(mt[mreq_n]));
      end
      check("rf_out", rf_out, exp_rf());
      check("rd_port", N*W'({rd_valid, rd_retrieving, rd_locked, rd_tag, rd_val}),
            N*W'({mv[rd_num], mr[rd_num], ml[rd_num], mt[rd_num], mval[rd_num]}));
    end
  end

  task automatic cyc(input bit v, input int op, input int num, input logic [TW-1:0] tag,
                     input logic [VW-1:0] data, input bit rdy, input bit rv, input int rn,
                     input logic [VW-1:0] rdata);
    cmd_valid = v; cmd_op = 3'(op); cmd_num = NW'(num); cmd_tag = tag; cmd_data = data;
    mem_req_ready = rdy; mem_rsp_valid = rv; mem_rsp_num = NW'(rn); mem_rsp_data = rdata;
    rd_num = NW'($urandom_range(0, N - 1));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, '0, '0, rdy, 0, 0, '0);
  endtask

  function automatic logic [W-1:0] slot_of(input int i);
    return rf_out[i*W +: W];
  endfunction

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lit_reset_rf", rf_out, '0);
    check("lit_reset_req", N*W'(mem_req_valid), '0);
    rst = 1'b0;

    // Single fetch with latency and response
    cyc(1, 1, 2, 16'h1234, '0, 1, 0, 0, '0);
    idle(1);
    check("lit_req_valid", N*W'(mem_req_valid), N*W'(1));
    check("lit_req_num", N*W'(mem_req_num), N*W'(2));
    check("lit_req_tag", N*W'(mem_req_tag), N*W'(16'h1234));
    idle(1);
    cyc(0, 0, 0, '0, '0, 1, 1, 2, 16'hBEEF);
    check("lit_slot2", N*W'(slot_of(2)), N*W'({3'b100, 16'h1234, 16'hBEEF}));

    // Stalled request held, then round-robin grants
    cyc(1, 1, 0, 16'h0A00, '0, 0, 0, 0, '0);
    cyc(1, 1, 1, 16'h0A01, '0, 0, 0, 0, '0);
    cyc(1, 1, 3, 16'h0A03, '0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      check("lit_hold_num", N*W'({mem_req_valid, mem_req_num}), N*W'({1'b1, 2'd0}));
    end
    idle(1);
    check("lit_grant1", N*W'({mem_req_valid, mem_req_num}), N*W'({1'b1, 2'd1}));
    idle(1);
    check("lit_grant3", N*W'({mem_req_valid, mem_req_num}), N*W'({1'b1, 2'd3}));
    idle(1);
    check("lit_grant_done", N*W'(mem_req_valid), '0);
    cyc(0, 0, 0, '0, '0, 0, 1, 0, 16'hA000);
    cyc(0, 0, 0, '0, '0, 0, 1, 1, 16'hA001);
    cyc(0, 0, 0, '0, '0, 0, 1, 3, 16'hA003);

    // Lock blocks WRITE, unlock allows it
    cyc(1, 2, 1, '0, '0, 0, 0, 0, '0);
    saved = rf_out;
    cyc(1, 4, 1, 16'hFFFF, 16'hFFFF, 0, 0, 0, '0);
    check("lit_locked_err", N*W'({cmd_ack, cmd_err}), N*W'(2'b01));
    check("lit_locked_keep", rf_out, saved);
    cyc(1, 3, 1, '0, '0, 0, 0, 0, '0);
    cyc(1, 4, 1, 16'h00AA, 16'h0055, 0, 0, 0, '0);
    check("lit_write_ack", N*W'({cmd_ack, cmd_err}), N*W'(2'b10));
    check("lit_slot1", N*W'(slot_of(1)), N*W'({3'b100, 16'h00AA, 16'h0055}));

    // Response to an EMPTY slot is dropped
    cyc(1, 5, 0, '0, '0, 0, 0, 0, '0);
    saved = rf_out;
    cyc(0, 0, 0, '0, '0, 0, 1, 0, 16'hDEAD);
    check("lit_drop_rsp", rf_out, saved);

    // Response and INVAL on the same slot in one cycle
    cyc(1, 1, 3, 16'h0333, '0, 1, 0, 0, '0);
    idle(1);
    idle(1);
    cyc(1, 5, 3, '0, '0, 0, 1, 3, 16'h7777);
    check("lit_inval_err", N*W'({cmd_ack, cmd_err}), N*W'(2'b01));
    check("lit_slot3", N*W'(slot_of(3)), N*W'({3'b100, 16'h0333, 16'h7777}));

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      int iss[$];
      int rn;
      bit rv;
      for (int i = 0; i < N; i++) if (mr[i] && mi[i]) iss.push_back(i);
      rv = 0; rn = 0;
      if (iss.size() > 0 && $urandom_range(0, 1) == 1) begin
        rv = 1; rn = iss[$urandom_range(0, iss.size() - 1)];
      end else if ($urandom_range(0, 9) == 0) begin
        rv = 1; rn = $urandom_range(0, N - 1);
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, N - 1),
          TW'($urandom), VW'($urandom), $urandom_range(0, 2) != 0, rv, rn, VW'($urandom));
    end

    // Async reset while a request is stalled
    rst = 1'b1; #1; rst = 1'b0; #1;
    model_reset();
    idle(0);
    cyc(1, 1, 0, 16'h5A5A, '0, 0, 0, 0, '0);
    idle(0);
    idle(0);
    check("lit_pre_rst_req", N*W'(mem_req_valid), N*W'(1));
    rst = 1'b1;
    #1;
    check("lit_rst_req", N*W'(mem_req_valid), '0);
    check("lit_rst_rf", rf_out, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, '0, '0, 1, 1, 0, 16'h9999);
    check("lit_rst_drop", rf_out, '0);
    idle(1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_slot_array.md
# rf_slot_array

Parametrised per-core register-file slot array for threadbrain. Holds one slot per core (valid, retrieving, locked, tag, value), accepts one command per cycle, and fetches tagged values from memory through a round-robin request port. The full slot state is exported as a packed bus, and a combinational indexed read port is provided.

## Interface
Parameters:
- `NCORES`, 4: number of slots/cores, ≥2.
- `TAG_W`, 16: tag width.
- `VAL_W`, 16: value width.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command strobe.
- `cmd_op`  in  3  NOP=0, FETCH=1, LOCK=2, UNLOCK=3, WRITE=4, INVAL=5.
- `cmd_num`  in  $clog2(NCORES)  target slot.
- `cmd_tag`  in  TAG_W  tag for FETCH/WRITE.
- `cmd_data`  in  VAL_W  value for WRITE.
- `cmd_ack`  out  1  registered pulse: command applied.
- `cmd_err`  out  1  registered pulse: command rejected.
- `mem_req_valid`  out  1  memory fetch request.
- `mem_req_ready`  in  1  request accepted when valid&ready.
- `mem_req_num`  out  $clog2(NCORES)  requesting slot.
- `mem_req_tag`  out  TAG_W  tag to fetch.
- `mem_rsp_valid`  in  1  response strobe.
- `mem_rsp_num`  in  $clog2(NCORES)  responding slot.
- `mem_rsp_data`  in  VAL_W  fetched value.
- `rd_num`  in  $clog2(NCORES)  read-port index.
- `rd_valid`, `rd_retrieving`, `rd_locked`  out  1 each; `rd_tag` out TAG_W; `rd_val` out VAL_W: fields of slot `rd_num`, combinational.
- `rf_out`  out  NCORES*W  packed state, W=3+TAG_W+VAL_W; slot i at [i*W +: W], fields MSB→LSB valid, retrieving, locked, tag, val.

## Operation
- Slot state: EMPTY (v=0,r=0), FETCHING (r=1), READY (v=1,r=0); `locked` orthogonal. Internal `issued` bit per slot.
- FETCH: legal from EMPTY/READY when unlocked → tag:=cmd_tag, v:=0, r:=1, issued:=0. Rejected if locked or FETCHING.
- WRITE: legal when unlocked and not FETCHING → tag, val := cmd; v:=1.
- INVAL: legal when unlocked and not FETCHING → v:=0.
- LOCK/UNLOCK: always legal, set/clear locked; LOCK on locked slot still acks.
- NOP with cmd_valid: no ack, no err.
- Arbiter: round-robin over slots with r=1 & issued=0; pointer starts at 0, advances to grant+1 on handshake; request held stable (num, tag) while valid & !ready. Handshake sets issued.
- Response: applied only if target has r=1 & issued=1 → val:=data, v:=1, r:=0, issued:=0; otherwise silently dropped.
- Same-slot response and command in one cycle: command legality evaluated on pre-cycle state; response applied, then LOCK/UNLOCK bit effect; FETCH/WRITE/INVAL on that slot therefore rejected.
- Locked slots still complete outstanding fetches.

## Timing
- Reset: all slots zero (v=r=locked=0, tag=val=0), issued=0, pointer=0, cmd_ack=cmd_err=0, mem_req_valid=0, mem_req_num=0, mem_req_tag=0.
- Command effect visible on `rf_out`/rd port the cycle after cmd_valid; ack/err same cycle as effect.
- mem_req_valid earliest one cycle after FETCH is applied (two after command); registered output.
- Response visible on rf_out one cycle after mem_rsp_valid.
- Back-to-back commands each cycle supported; throughput one command, one request handshake, one response per cycle concurrently.
- Reset asserted mid-fetch: request dropped immediately, later responses dropped (slot not FETCHING).

## Structure
- Package `rf_pkg`: op enum, slot struct/field offsets, width function W(TAG_W,VAL_W).
- Sub-module `rf_rr_arb`: NCORES-wide round-robin arbiter with hold-on-stall.
- Read port is a pure index mux over `rf_out`.

## Test plan
- Reset then FETCH slot 2 tag 0x1234, ready=1 → req num=2 tag=0x1234 two cycles later; response data 0xBEEF → slot 2 v=1,r=0,val=0xBEEF.
- FETCH slots 0,1,3 same window, ready held 0 for 5 cycles → req stays num=0 stable; then grants 0,1,3 in order.
- LOCK slot 1, WRITE slot 1 → cmd_err=1, slot unchanged; UNLOCK, WRITE 0x00AA/0x0055 → ack, v=1.
- Response for slot 0 while EMPTY → dropped, rf_out unchanged.
- Response to slot 3 same cycle as INVAL slot 3 → value loaded (v=1), cmd_err=1.
- Async rst mid-request (valid&!ready) → mem_req_valid=0 without clock edge; all rf_out bits 0.
